// File: rtl/reg_bus_master.sv
// Register-bus master: queues host commands in a 4-entry FIFO and executes them one at a
// time against a downstream register port, returning one response per command.
// Optional feature: define REG_BUS_MASTER_TIMEOUT_EN to abort stalled transfers with rsp_err.
module reg_bus_master (
  input  logic       CLK,
  input  logic       RST_N,
  // host command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic       cmd_wdata,
  // downstream write port
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  // downstream read port
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  // host response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [2:0] rsp_addr,
  output logic       rsp_rdata,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRsp} state_e;

  state_e     state_q, state_d;

  logic [4:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       fifo_empty;
  logic [4:0] head;
  logic       push, pop;

  logic [2:0] addr_q;
  logic       wdata_q;
  logic       rsp_write_q;
  logic       rsp_rdata_q;

  logic       stall;
  logic       timeout;

  assign fifo_empty = (count_q == 3'd0);
  assign head       = fifo_mem[rd_ptr_q];
  // Gated by RST_N so the host never sees ready while the block is held in reset.
  assign cmd_ready  = RST_N && (count_q < 3'd4);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == StIdle) && !fifo_empty;

  // FIFO storage: data only, validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = head[4] ? StWr : StRd;
      StWr:   if (write_rdy || timeout) state_d = StRsp;
      StRd:   if (read_rdy || timeout) state_d = StRsp;
      StRsp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; addresses and data are forced to zero whenever their enable is low.
  always_comb begin
    write_en      = (state_q == StWr);
    read_en       = (state_q == StRd);
    write_address = write_en ? addr_q : 3'd0;
    write_data    = write_en ? wdata_q : 1'b0;
    read_address  = read_en ? addr_q : 3'd0;
    rsp_valid     = (state_q == StRsp);
    busy          = !fifo_empty || (state_q != StIdle);
  end

  assign stall = (write_en && !write_rdy) || (read_en && !read_rdy);

  // Latch the popped command and build the response fields on completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q      <= 3'd0;
      wdata_q     <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= head[3:1];
        wdata_q <= head[0];
      end
      if (write_en && write_rdy) begin
        rsp_write_q <= 1'b1;
        rsp_rdata_q <= 1'b0;
      end else if (read_en && read_rdy) begin
        rsp_write_q <= 1'b0;
        rsp_rdata_q <= read_data;
      end else if (timeout) begin
        rsp_write_q <= write_en;
        rsp_rdata_q <= 1'b0;
      end
    end
  end

  assign rsp_write = rsp_write_q;
  assign rsp_addr  = addr_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       rsp_err_q;

  // The edge that would take the counter to 255 aborts the transfer, so the enable
  // stays high for exactly 255 stalled cycles.
  assign timeout = stall && (wait_q == 8'd254);

  // Stall counter (zero outside WR/RD, so it starts cleared on entry) and error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_q    <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (write_en || read_en) begin
        if (stall) wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= 8'd0;
      end
      if (pop) begin
        rsp_err_q <= 1'b0;
      end else if (timeout) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed self-checking bench for reg_bus_master.
module tb_reg_bus_master;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_wdata;
  logic [2:0] cmd_addr;
  logic [2:0] write_address, read_address, rsp_addr;
  logic       write_data, write_en, write_rdy;
  logic       read_en, read_data, read_rdy;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_rdata, rsp_err, busy;

  int checks = 0;
  int errors = 0;

  reg_bus_master dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_addr      (rsp_addr),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [2:0] a, input logic d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    logic [2:0] kk;
    RST_N = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = 1'b0;
    write_rdy = 1'b0; read_rdy = 1'b0; read_data = 1'b0; rsp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_write_en", 8'(write_en), 8'd0);
    chk("rst_read_en", 8'(read_en), 8'd0);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_err", 8'(rsp_err), 8'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("idle_cmd_ready", 8'(cmd_ready), 8'd1);

    // Single write, minimum latency
    write_rdy = 1'b1;
    send(1'b1, 3'd4, 1'b1);
    tick();                       // edge N: push
    cmd_valid = 1'b0;
    chk("wr_n_en", 8'(write_en), 8'd0);
    chk("wr_n_addr_zero", 8'(write_address), 8'd0);
    chk("wr_n_busy", 8'(busy), 8'd1);
    tick();                       // edge N+1: pop into WR
    chk("wr_en", 8'(write_en), 8'd1);
    chk("wr_addr", 8'(write_address), 8'd4);
    chk("wr_data", 8'(write_data), 8'd1);
    chk("wr_no_read", 8'(read_en), 8'd0);
    tick();                       // edge N+2: handshake
    chk("wr_en_pulse", 8'(write_en), 8'd0);
    chk("wr_rsp_valid", 8'(rsp_valid), 8'd1);
    chk("wr_rsp_write", 8'(rsp_write), 8'd1);
    chk("wr_rsp_addr", 8'(rsp_addr), 8'd4);
    chk("wr_rsp_rdata", 8'(rsp_rdata), 8'd0);
    chk("wr_rsp_err", 8'(rsp_err), 8'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_done_valid", 8'(rsp_valid), 8'd0);
    chk("wr_done_busy", 8'(busy), 8'd0);

    // Read with 5 stalled cycles
    read_rdy = 1'b0;
    send(1'b0, 3'd3, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rd_en_c1", 8'(read_en), 8'd1);
    chk("rd_addr", 8'(read_address), 8'd3);
    chk("rd_no_write", 8'(write_en), 8'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) begin
        read_rdy  = 1'b1;
        read_data = 1'b1;
      end
      chk("rd_en_held", 8'(read_en), 8'd1);
    end
    tick();
    read_rdy  = 1'b0;
    read_data = 1'b0;
    chk("rd_en_drop", 8'(read_en), 8'd0);
    chk("rd_addr_zero", 8'(read_address), 8'd0);
    chk("rd_rsp_valid", 8'(rsp_valid), 8'd1);
    chk("rd_rsp_rdata", 8'(rsp_rdata), 8'd1);
    chk("rd_rsp_addr", 8'(rsp_addr), 8'd3);
    chk("rd_rsp_write", 8'(rsp_write), 8'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Backpressure: 5 writes with write_rdy low, then drain in order
    write_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      kk = 3'(i);
      send(1'b1, kk, kk[0]);
      tick();
    end
    chk("bp_cmd_ready_low", 8'(cmd_ready), 8'd0);
    chk("bp_wr_en", 8'(write_en), 8'd1);
    send(1'b1, 3'd7, 1'b1);       // must not be accepted
    tick();
    chk("bp_still_full", 8'(cmd_ready), 8'd0);
    cmd_valid = 1'b0;
    write_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      kk = 3'(k);
      chk("bp_wr_en_k", 8'(write_en), 8'd1);
      chk("bp_wr_addr_k", 8'(write_address), 8'(kk));
      chk("bp_wr_data_k", 8'(write_data), 8'(kk[0]));
      tick();
      chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
      chk("bp_rsp_addr", 8'(rsp_addr), 8'(kk));
      tick();                     // hold response with rsp_ready low
      chk("bp_rsp_hold", 8'(rsp_valid), 8'd1);
      chk("bp_rsp_addr_hold", 8'(rsp_addr), 8'(kk));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_rsp_gone", 8'(rsp_valid), 8'd0);
      tick();
    end
    chk("bp_drained_busy", 8'(busy), 8'd0);
    chk("bp_drained_wr_en", 8'(write_en), 8'd0);

    // Reset in the middle of a write
    write_rdy = 1'b0;
    send(1'b1, 3'd5, 1'b1);
    tick();
    send(1'b0, 3'd6, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("mr_wr_en_before", 8'(write_en), 8'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mr_wr_en_async", 8'(write_en), 8'd0);
    chk("mr_busy_async", 8'(busy), 8'd0);
    chk("mr_cmd_ready", 8'(cmd_ready), 8'd0);
    chk("mr_wr_addr", 8'(write_address), 8'd0);
    tick();
    RST_N = 1'b1;
    write_rdy = 1'b1;
    read_rdy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_rsp", 8'(rsp_valid), 8'd0);
      chk("mr_no_en", 8'({write_en, read_en}), 8'd0);
    end
    read_rdy = 1'b0;

    // Stalled read: timeout build aborts after 255 cycles, default build waits
    send(1'b0, 3'd2, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("to_rd_en", 8'(read_en), 8'd1);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
    for (int i = 0; i < 254; i++) tick();
    chk("to_rd_en_254", 8'(read_en), 8'd1);
    tick();
    chk("to_rd_en_drop", 8'(read_en), 8'd0);
    chk("to_rsp_valid", 8'(rsp_valid), 8'd1);
    chk("to_rsp_err", 8'(rsp_err), 8'd1);
    chk("to_rsp_rdata", 8'(rsp_rdata), 8'd0);
    chk("to_rsp_addr", 8'(rsp_addr), 8'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_done_busy", 8'(busy), 8'd0);
`else
    for (int i = 0; i < 299; i++) tick();
    chk("nto_rd_en_300", 8'(read_en), 8'd1);
    chk("nto_no_rsp", 8'(rsp_valid), 8'd0);
    chk("nto_rsp_err", 8'(rsp_err), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
